load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 134 +++++++++++++
 tb/tb_load_store_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one bus transaction at a time (store 3 cycles, load 4+), stalls on mem_req_ready/mem_rvalid.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault without a bus request.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic [4:0]  rd_out,
  output logic        misaligned,
  output logic        busy,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        st_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic        trap;
  logic        size_word, size_half;
  logic [1:0]  lane;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_ext;
  logic [3:0]  strb;
  logic        accept;

  assign accept = (state == IDLE) && req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;
  assign trap = funct3[1] ? (addr[1:0] != 2'b00) : (funct3[0] & addr[0]);

  always_ff @(posedge clk) begin
    if (reset)       mis_q <= 1'b0;
    else if (accept) mis_q <= trap;
  end
  assign misaligned = mis_q;
`else
  assign trap       = 1'b0;
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = trap ? RESP : REQ;
      REQ:     if (mem_req_ready) state_nxt = st_q ? RESP : WAIT;
      WAIT:    if (mem_rvalid) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // funct3[1] set covers LW/SW and the unused codes 3,6,7; low address bits below the access size are dropped.
  assign size_word = f3_q[1];
  assign size_half = ~f3_q[1] & f3_q[0];
  assign lane      = size_word ? 2'b00 : (size_half ? {addr_q[1], 1'b0} : addr_q[1:0]);

  assign half_sel = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign byte_sel = lane[0] ? half_sel[15:8] : half_sel[7:0];

  always_comb begin
    if (size_word)
      load_ext = mem_rdata;
    else if (size_half)
      load_ext = {{16{~f3_q[2] & half_sel[15]}}, half_sel};
    else
      load_ext = {{24{~f3_q[2] & byte_sel[7]}}, byte_sel};
  end

  always_comb begin
    if (size_word) begin
      strb      = 4'b1111;
      mem_wdata = sdata_q;
    end else if (size_half) begin
      strb      = lane[1] ? 4'b1100 : 4'b0011;
      mem_wdata = {2{sdata_q[15:0]}};
    end else begin
      strb      = 4'b0001 << lane;
      mem_wdata = {4{sdata_q[7:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= 1'b0;
      f3_q      <= 3'd0;
      addr_q    <= 32'd0;
      sdata_q   <= 32'd0;
      rd_out    <= 5'd0;
      load_data <= 32'd0;
    end else if (accept) begin
      st_q      <= is_store;
      f3_q      <= funct3;
      addr_q    <= addr;
      sdata_q   <= store_data;
      rd_out    <= rd_in;
      load_data <= 32'd0;
    end else if ((state == WAIT) && mem_rvalid) begin
      load_data <= load_ext;
    end
  end

  assign req_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign resp_valid    = (state == RESP);
  assign mem_req_valid = (state == REQ);
  assign mem_we        = mem_req_valid & st_q;
  assign mem_wstrb     = mem_we ? strb : 4'b0000;
  assign mem_addr      = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed literal cases plus randomized traffic against a transaction-level model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        resp_valid;
  logic [31:0] load_data;
  logic [4:0]  rd_out;
  logic        misaligned;
  logic        busy;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3), .addr(addr),
    .store_data(store_data), .rd_in(rd_in),
    .resp_valid(resp_valid), .load_data(load_data), .rd_out(rd_out),
    .misaligned(misaligned), .busy(busy),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: access size in bytes, byte offset aligned down to the size.
  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int acc_off(input logic [2:0] f3, input logic [31:0] a);
    int s  = acc_size(f3);
    int lo = int'(a[1:0]);
    return (lo / s) * s;
  endfunction

  function automatic bit is_misal(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % acc_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    int m = (1 << acc_size(f3)) - 1;
    return 4'(m << acc_off(f3, a));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (acc_size(f3))
      1:       return {24'd0, sd[7:0]} * 32'h0101_0101;
      2:       return {16'd0, sd[15:0]} * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
    int s = acc_size(f3);
    logic [31:0] v, mask;
    if (s == 4) return rdata;
    mask = (32'd1 << (8 * s)) - 32'd1;
    v = (rdata >> (8 * acc_off(f3, a))) & mask;
    if ((f3 == 3'd0 || f3 == 3'd1) && v[8 * s - 1]) v = v | ~mask;
    return v;
  endfunction

  bit          exp_bus = 1'b0;
  logic [31:0] exp_addr, exp_wdata, exp_ld;
  logic [3:0]  exp_strb;
  logic        exp_we, exp_mis;
  logic [4:0]  exp_rd;
  int          resp_cnt = 0;
  int          exp_resp_cnt = 0;

  // Every-cycle comparison of the bus and response outputs against the model's expectations.
  always @(negedge clk) begin
    if (!reset) begin
      check("busy_vs_ready", busy, !req_ready);
      if (mem_req_valid) begin
        check("bus_req_expected", exp_bus, 1'b1);
        if (exp_bus) begin
          check("mem_addr", mem_addr, exp_addr);
          check("mem_we", mem_we, exp_we);
          if (exp_we) begin
            check("mem_wstrb", mem_wstrb, exp_strb);
            check("mem_wdata", mem_wdata, exp_wdata);
          end
        end
      end
      if (resp_valid) begin
        resp_cnt++;
        check("load_data", load_data, exp_ld);
        check("rd_out", rd_out, exp_rd);
        check("misaligned", misaligned, exp_mis);
      end
    end
  end

  logic [31:0] last_addr, last_wdata, last_ld;
  logic [3:0]  last_strb;
  logic        last_mis;

  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] rd, input int rdy_dly,
                       input int rv_dly, input logic [31:0] rdata);
    bit trap = TRAP && is_misal(f3, a);
    exp_addr  = a & ~32'h3;
    exp_we    = st;
    exp_strb  = model_strb(f3, a);
    exp_wdata = model_wdata(f3, sd);
    exp_rd    = rd;
    exp_mis   = trap;
    exp_ld    = (st || trap) ? 32'd0 : model_load(f3, a, rdata);
    exp_bus   = !trap;
    exp_resp_cnt++;
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; rd_in = rd;
    @(negedge clk);
    req_valid = 1'b0; addr = $urandom; store_data = $urandom; rd_in = 5'($urandom);
    funct3 = 3'($urandom); is_store = 1'($urandom);
    if (!trap) begin
      last_addr = mem_addr; last_strb = mem_wstrb; last_wdata = mem_wdata;
      for (int i = 0; i < rdy_dly; i++) begin
        check("stall_valid", mem_req_valid, 1'b1);
        check("stall_req_ready", req_ready, 1'b0);
        check("stall_busy", busy, 1'b1);
        if (i > 0) begin
          check("stall_addr_stable", mem_addr, last_addr);
          check("stall_wstrb_stable", mem_wstrb, last_strb);
          check("stall_wdata_stable", mem_wdata, last_wdata);
        end
        mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        @(negedge clk);
      end
      mem_rvalid = 1'b0; mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0; exp_bus = 1'b0;
      if (!st) begin
        for (int i = 0; i < rv_dly; i++) begin
          check("wait_no_resp", resp_valid, 1'b0);
          @(negedge clk);
        end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
    end
    last_ld = load_data; last_mis = misaligned;
    check("resp_valid", resp_valid, 1'b1);
    mem_rvalid = 1'($urandom); mem_rdata = $urandom;
    @(negedge clk);
    check("resp_one_cycle", resp_valid, 1'b0);
    for (int g = $urandom_range(0, 2); g > 0; g--) begin
      mem_rvalid = 1'($urandom); mem_rdata = $urandom;
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_wstrb", mem_wstrb, 4'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_rd_out", rd_out, 5'd0);
    check("rst_misaligned", misaligned, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    do_op(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 5'd5, 0, 0, 32'h0);
    check("sw_addr", last_addr, 32'h100);
    check("sw_wstrb", last_strb, 4'b1111);
    check("sw_wdata", last_wdata, 32'hDEAD_BEEF);

    do_op(1'b0, 3'd0, 32'h103, 32'h0, 5'd9, 1, 2, 32'h80FF_7F01);
    check("lb_data", last_ld, 32'hFFFF_FF80);
    do_op(1'b0, 3'd4, 32'h103, 32'h0, 5'd10, 0, 0, 32'h80FF_7F01);
    check("lbu_data", last_ld, 32'h0000_0080);
    do_op(1'b0, 3'd1, 32'h102, 32'h0, 5'd11, 0, 1, 32'h8001_FFFF);
    check("lh_data", last_ld, 32'hFFFF_8001);
    do_op(1'b1, 3'd1, 32'h102, 32'h0000_1234, 5'd12, 0, 0, 32'h0);
    check("sh_wstrb", last_strb, 4'b1100);
    check("sh_wdata", last_wdata, 32'h1234_1234);

    do_op(1'b1, 3'd2, 32'h40, 32'h0BAD_F00D, 5'd13, 5, 0, 32'h0);

    do_op(1'b0, 3'd2, 32'h101, 32'h0, 5'd14, 0, 0, 32'hCAFE_F00D);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_flag", last_mis, 1'b1);
    check("lw_mis_data", last_ld, 32'h0);
`else
    check("lw_trunc_addr", last_addr, 32'h100);
    check("lw_trunc_mis", last_mis, 1'b0);
    check("lw_trunc_data", last_ld, 32'hCAFE_F00D);
`endif

    // Reset while waiting for read data: the response is abandoned.
    exp_addr = 32'h200; exp_we = 1'b0; exp_bus = 1'b1;
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h200; rd_in = 5'd7;
    @(negedge clk);
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; exp_bus = 1'b0;
    check("wait_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rstw_resp_valid", resp_valid, 1'b0);
    check("rstw_req_ready", req_ready, 1'b1);
    check("rstw_busy", busy, 1'b0);
    check("rstw_load_data", load_data, 32'h0);
    check("rstw_rd_out", rd_out, 5'd0);
    @(negedge clk);
    check("rstw_no_late_resp", resp_valid, 1'b0);

    for (int n = 0; n < 150; n++) begin
      bit st = 1'($urandom);
      int k = $urandom_range(0, 5);
      logic [2:0] f3 = st ? 3'((k < 4) ? k : k + 2) : 3'($urandom_range(0, 7));
      do_op(st, f3, $urandom, $urandom, 5'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom);
    end

    @(negedge clk);
    #1;
    check("resp_count", resp_cnt, exp_resp_cnt);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
